// File: rtl/sipo_frame_pkg.sv
// Shared definitions for the serial-frame capture controller.
// State encodings and the parity helper used when SIPO_FRAME_PARITY_EN is defined.
package sipo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } sipo_state_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  // Even parity check: 1 when data plus parity bit has an odd number of ones.
  function automatic logic even_par_err(input logic [31:0] data, input logic pbit);
    return ^{data, pbit};
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit right-shifting serial-in register: new bit enters the MSB,
// with a shift enable and a synchronous clear.
module sipo_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_si,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Shift register state; clear takes priority over shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= {WIDTH{1'b0}};
    end else if (i_clr) begin
      r_q <= {WIDTH{1'b0}};
    end else if (i_shift) begin
      r_q <= {i_si, r_q[WIDTH-1:1]};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Serial frame capture: start bit, WIDTH data bits (LSB first), optional even
// parity bit when SIPO_FRAME_PARITY_EN is defined; word presented over valid/ready.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             en,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
`ifdef SIPO_FRAME_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_word;
  logic             w_start;
  logic             w_shift;
  logic             w_last;
  logic             w_done;
  logic             w_accept;
  logic             w_load;
  logic             w_drop;

  assign w_start = en && !si && (r_state == ST_IDLE);
  assign w_shift = en && (r_state == ST_SHIFT);
  assign w_last  = w_shift && (r_bitcnt == LAST);

`ifdef SIPO_FRAME_PARITY_EN
  // The last data bit is already in the core; this edge samples the parity bit.
  assign w_done = en && (r_state == ST_PARITY);
  assign w_word = w_q;
`else
  // Load the word including the bit being sampled on this edge.
  assign w_done = w_last;
  assign w_word = {si, w_q[WIDTH-1:1]};
  logic w_unused_lsb;
  assign w_unused_lsb = w_q[0];
`endif

  assign w_accept = po_valid && po_ready;
  assign w_load   = w_done && (!po_valid || po_ready);
  assign w_drop   = w_done && po_valid && !po_ready;

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_shift (w_shift),
    .i_si    (si),
    .o_q     (w_q)
  );

  // Frame sequencing next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_SHIFT;
        else         w_state_nxt = ST_IDLE;
      end
      ST_SHIFT: begin
`ifdef SIPO_FRAME_PARITY_EN
        if (w_last) w_state_nxt = ST_PARITY;
        else        w_state_nxt = ST_SHIFT;
`else
        if (w_last) w_state_nxt = ST_IDLE;
        else        w_state_nxt = ST_SHIFT;
`endif
      end
`ifdef SIPO_FRAME_PARITY_EN
      ST_PARITY: begin
        if (en) w_state_nxt = ST_IDLE;
        else    w_state_nxt = ST_PARITY;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM, bit counter, holding register and overrun flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= {CW{1'b0}};
      busy     <= 1'b0;
      po       <= {WIDTH{1'b0}};
      po_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != ST_IDLE);

      if (w_start || w_last) r_bitcnt <= {CW{1'b0}};
      else if (w_shift)      r_bitcnt <= r_bitcnt + CW'(1);
      else                   r_bitcnt <= r_bitcnt;

      if (w_load) begin
        po       <= w_word;
        po_valid <= 1'b1;
      end else if (w_accept) begin
        po_valid <= 1'b0;
      end else begin
        po_valid <= po_valid;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop)       overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      else              overrun <= overrun;
    end
  end

`ifdef SIPO_FRAME_PARITY_EN
  // Parity status travels with po; dropped frames leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else if (w_load) begin
      parity_err <= even_par_err(32'(w_word), si);
    end else if (w_accept) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_err;
    end
  end
`endif

endmodule
